// File: rtl/hazard_ctrl.sv
// Pipeline hazard/control unit for the 5-stage RV32I core: reset flush sequencing,
// forwarding, load-use and branch hazards, memory-wait freeze. Optional perf counters: HAZARD_PERF_EN.
module hazard_ctrl #(
    parameter int unsigned INIT_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs1D_i,
    input  logic [4:0] Rs2D_i,
    input  logic [4:0] Rs1E_i,
    input  logic [4:0] Rs2E_i,
    input  logic [4:0] RdE_i,
    input  logic       LoadE_i,
    input  logic       PCSrcE_i,
    input  logic [4:0] RdM_i,
    input  logic       RegWriteM_i,
    input  logic       MemAccessM_i,
    input  logic       DMemReady_i,
    input  logic [4:0] RdW_i,
    input  logic       RegWriteW_i,
    output logic       StallF_o,
    output logic       StallD_o,
    output logic       StallE_o,
    output logic       StallM_o,
    output logic       FlushD_o,
    output logic       FlushE_o,
    output logic       FlushW_o,
    output logic [1:0] ForwardAE_o,
    output logic [1:0] ForwardBE_o,
    output logic       MemTimeout_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] LoadStallCount_o,
    output logic [31:0] FlushCount_o,
    output logic [31:0] MemWaitCount_o
`endif
);

    typedef enum logic [1:0] {S_INIT, S_RUN, S_MEMWAIT, S_ERROR} state_e;

    state_e     state_q;
    logic [3:0] init_cnt_q;
    logic [7:0] wait_cnt_q;
    logic       timeout_q;

    logic memstall;
    logic lwstall;
    logic hazard_en;

    assign memstall  = MemAccessM_i & ~DMemReady_i;
    assign lwstall   = LoadE_i & (RdE_i != 5'd0) & ((RdE_i == Rs1D_i) | (RdE_i == Rs2D_i));
    assign hazard_en = ~rst & ((state_q == S_RUN) | (state_q == S_MEMWAIT));

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (RegWriteM_i && (RdM_i != 5'd0) && (RdM_i == rs))
            return 2'b10;
        else if (RegWriteW_i && (RdW_i != 5'd0) && (RdW_i == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        StallF_o    = 1'b0;
        StallD_o    = 1'b0;
        StallE_o    = 1'b0;
        StallM_o    = 1'b0;
        FlushD_o    = 1'b0;
        FlushE_o    = 1'b0;
        FlushW_o    = 1'b0;
        ForwardAE_o = 2'b00;
        ForwardBE_o = 2'b00;
        if (rst || state_q == S_INIT) begin
            StallF_o = 1'b1;
            FlushD_o = 1'b1;
            FlushE_o = 1'b1;
            FlushW_o = 1'b1;
        end else if (state_q == S_ERROR) begin
            StallF_o = 1'b1;
            StallD_o = 1'b1;
            StallE_o = 1'b1;
            StallM_o = 1'b1;
            FlushW_o = 1'b1;
        end else begin
            ForwardAE_o = fwd_sel(Rs1E_i);
            ForwardBE_o = fwd_sel(Rs2E_i);
            // Memory freeze masks branch/load-use; a held branch acts on release.
            if (memstall) begin
                StallF_o = 1'b1;
                StallD_o = 1'b1;
                StallE_o = 1'b1;
                StallM_o = 1'b1;
                FlushW_o = 1'b1;
            end else if (PCSrcE_i) begin
                FlushD_o = 1'b1;
                FlushE_o = 1'b1;
            end else if (lwstall) begin
                StallF_o = 1'b1;
                StallD_o = 1'b1;
                FlushE_o = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_INIT;
            init_cnt_q <= 4'd0;
            wait_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            case (state_q)
                S_INIT: begin
                    if (init_cnt_q == 4'(INIT_CYCLES - 1))
                        state_q <= S_RUN;
                    else
                        init_cnt_q <= init_cnt_q + 4'd1;
                end
                S_RUN: begin
                    if (memstall) begin
                        state_q    <= S_MEMWAIT;
                        wait_cnt_q <= 8'd1;
                    end
                end
                S_MEMWAIT: begin
                    if (!memstall) begin
                        state_q    <= S_RUN;
                        wait_cnt_q <= 8'd0;
                    end else if (wait_cnt_q == 8'(MEM_TIMEOUT)) begin
                        state_q   <= S_ERROR;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                default: state_q <= S_ERROR;
            endcase
        end
    end

    assign MemTimeout_o = timeout_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] lw_cnt_q;
    logic [31:0] flush_cnt_q;
    logic [31:0] mem_cnt_q;

    // Counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            lw_cnt_q    <= 32'd0;
            flush_cnt_q <= 32'd0;
            mem_cnt_q   <= 32'd0;
        end else if (hazard_en) begin
            if (memstall) begin
                if (mem_cnt_q != '1) mem_cnt_q <= mem_cnt_q + 32'd1;
            end else if (PCSrcE_i) begin
                if (flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 32'd1;
            end else if (lwstall) begin
                if (lw_cnt_q != '1) lw_cnt_q <= lw_cnt_q + 32'd1;
            end
        end
    end

    assign LoadStallCount_o = lw_cnt_q;
    assign FlushCount_o     = flush_cnt_q;
    assign MemWaitCount_o   = mem_cnt_q;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage RV32I core.
- Drives the stall, flush and forward controls of the F/D, D/E, E/M and M/W pipeline registers.
- Sequences a post-reset flush of the pipeline registers, which have no reset of their own.
- Freezes the pipeline while data memory is not ready, with a sticky timeout error.

Parameters:
- INIT_CYCLES, 2, cycles of forced flush after reset (1..15).
- MEM_TIMEOUT, 64, max consecutive not-ready cycles before error (2..255).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- Rs1D_i  in  5  rs1 of instruction in Decode
- Rs2D_i  in  5  rs2 of instruction in Decode
- Rs1E_i  in  5  rs1 in Execute
- Rs2E_i  in  5  rs2 in Execute
- RdE_i  in  5  rd in Execute
- LoadE_i  in  1  Execute instruction is a load
- PCSrcE_i  in  1  taken branch/jump resolved in Execute
- RdM_i  in  5  rd in Memory
- RegWriteM_i  in  1  Memory stage writes register
- MemAccessM_i  in  1  Memory stage accesses data memory
- DMemReady_i  in  1  data memory ready
- RdW_i  in  5  rd in Writeback
- RegWriteW_i  in  1  Writeback writes register
- StallF_o  out  1  hold PC
- StallD_o  out  1  hold F/D register
- StallE_o  out  1  hold D/E register
- StallM_o  out  1  hold E/M register
- FlushD_o  out  1  bubble F/D
- FlushE_o  out  1  bubble D/E
- FlushW_o  out  1  bubble M/W
- ForwardAE_o  out  2  operand A select: 00 regfile, 01 W result, 10 M ALU result
- ForwardBE_o  out  2  operand B select, same encoding
- MemTimeout_o  out  1  sticky memory timeout error

Behaviour:
- FSM states: INIT, RUN, MEMWAIT, ERROR. An 8-bit wait counter and a 4-bit init counter are the only other state.
- Reset: rst high sets state INIT, both counters 0 and MemTimeout_o 0 on the next edge. rst mid-operation overrides every other event.
- While rst is high, outputs show the INIT pattern.

- INIT:
  - StallF=1, FlushD=1, FlushE=1, FlushW=1; all other stalls 0.
  - Forward outputs are 00.
  - Stays for exactly INIT_CYCLES cycles after rst falls, then moves to RUN.

- Forwarding (combinational, RUN and MEMWAIT):
  - ForwardAE=10 if RegWriteM_i and RdM_i!=0 and RdM_i==Rs1E_i.
  - Otherwise 01 if RegWriteW_i and RdW_i!=0 and RdW_i==Rs1E_i.
  - Otherwise 00. M has priority over W. ForwardBE uses the same rule with Rs2E_i.

- Memory stall:
  - memstall = MemAccessM_i & !DMemReady_i.
  - In RUN, when memstall is asserted: assert StallF, StallD, StallE, StallM and FlushW in that same cycle, load the wait counter with 1 and go to MEMWAIT.
  - In MEMWAIT, outputs stay the same while memstall holds, and the counter increments.
  - The first cycle with memstall=0 drops all stalls combinationally and returns to RUN.
  - If the counter equals MEM_TIMEOUT while memstall still holds: go to ERROR and set MemTimeout_o.
  - ERROR: all stalls plus FlushW asserted permanently; exit only via rst.
  - Load-use and branch actions are suppressed while memstall is asserted. The held PCSrcE_i takes effect on release.

- Load-use (RUN, no memstall):
  - lwstall = LoadE_i & RdE_i!=0 & (RdE_i==Rs1D_i | RdE_i==Rs2D_i).
  - lwstall gives StallF=1, StallD=1, FlushE=1 for one cycle.

- Branch (RUN, no memstall):
  - PCSrcE_i gives FlushD=1, FlushE=1.
  - If lwstall and PCSrcE_i are both asserted, the branch wins: no stall, and FlushD/FlushE are asserted.

- Register x0 never triggers forwarding or a load-use stall.
- Forwarding and hazard detection are combinational (zero latency); only FSM state, the counters, MemTimeout_o and the optional perf counters are registered.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined, adds three output ports, each 32 bits, incremented on each qualifying RUN cycle, saturating at 0xFFFFFFFF and cleared by rst:
  - LoadStallCount_o, counts lwstall cycles.
  - FlushCount_o, counts PCSrcE_i flush cycles.
  - MemWaitCount_o, counts memstall cycles.
- When not defined, these ports and their counters do not exist.

Test Plan:
- rst 1 cycle, INIT_CYCLES=2 -> StallF/FlushD/FlushE/FlushW high for exactly 2 cycles after rst falls, then all low.
- LoadE_i=1, RdE_i=5, Rs1D_i=5 -> StallF=StallD=FlushE=1 for one cycle; with RdE_i=0 -> no stall.
- RdM_i=RdW_i=7, both RegWrite, Rs1E_i=7 -> ForwardAE=10; with RegWriteM_i=0 -> 01; with Rs2E_i=7 -> ForwardBE follows the same rule.
- lwstall and PCSrcE_i asserted together -> FlushD=FlushE=1, StallF=StallD=0.
- MemAccessM_i=1, DMemReady_i low 3 cycles -> four stalls plus FlushW high for 3 cycles, released the cycle ready rises; PCSrcE_i held during the wait flushes D/E on release.
- DMemReady_i held low, MEM_TIMEOUT=4 -> MemTimeout_o rises after 4 wait cycles and stays high after ready returns until rst.
